seven_seg_scan_driver: RTL and testbench

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: SEVEN_SEG_SCAN_DRIVER

---
 rtl/seven_seg_scan_driver.sv | 207 ++++++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver.
// Scans N_DIGITS hex digits, one slot of REFRESH_DIV cycles each, with an
// all-off guard window at the start of every slot to suppress ghosting.
// New values are staged in a pending register and only reach the display
// register at a frame wrap, so a frame never shows a mix of two values.
// Supports leading-zero blanking, per-digit blink and output polarity.
module seven_seg_scan_driver #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                      i_CLK,
  input  logic                      i_RST,
  input  logic [4*N_DIGITS-1:0]     i_VALUE,
  input  logic                      i_LOAD,
  input  logic [N_DIGITS-1:0]       i_DP,
  input  logic [N_DIGITS-1:0]       i_BLINK_EN,
  input  logic                      i_BLANK_LZ,
  output logic [6:0]                o_SEVEN_SEG,
  output logic                      o_DP,
  output logic [N_DIGITS-1:0]       o_DIGIT_EN,
  output logic                      o_FRAME_DONE
);

  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] GUARD_END = SLOT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);
  localparam logic              POL       = (ACTIVE_LOW != 0);

  // Hex nibble to segments, bit 6..0 = g..a, 1 = lit.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1100111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      4'hF:    seg = 7'b1110001;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  logic [SLOT_W-1:0]     slot_cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [BLK_W-1:0]      blk_cnt_r;
  logic                  blk_phase_r;
  logic                  pend_flag_r;
  logic [4*N_DIGITS-1:0] pend_val_r;
  logic [4*N_DIGITS-1:0] disp_val_r;

  logic [6:0]            seg_r;
  logic                  dp_r;
  logic [N_DIGITS-1:0]   en_r;
  logic                  frame_done_r;

  logic                  slot_last_s;
  logic                  wrap_s;
  logic                  guard_s;
  logic [N_DIGITS-1:0]   onehot_s;
  logic [N_DIGITS-1:0]   lz_mask_s;
  logic [3:0]            cur_nib_s;
  logic                  cur_dp_s;
  logic                  cur_blink_s;
  logic                  cur_lz_s;
  logic                  blinked_s;
  logic [6:0]            seg_s;
  logic                  dp_s;
  logic [N_DIGITS-1:0]   en_s;

  assign slot_last_s = (slot_cnt_r == SLOT_LAST);
  assign wrap_s      = slot_last_s && (idx_r == IDX_LAST);
  assign guard_s     = (slot_cnt_r < GUARD_END);

  // Slot counter and digit index; the index advances at each slot terminal count.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      slot_cnt_r <= {SLOT_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
    end else if (slot_last_s) begin
      slot_cnt_r <= {SLOT_W{1'b0}};
      idx_r      <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
    end else begin
      slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
      idx_r      <= idx_r;
    end
  end

  // Blink phase toggles once every BLINK_FRAMES frame wraps.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      blk_cnt_r   <= {BLK_W{1'b0}};
      blk_phase_r <= 1'b0;
    end else if (wrap_s) begin
      if (blk_cnt_r == BLK_LAST) begin
        blk_cnt_r   <= {BLK_W{1'b0}};
        blk_phase_r <= ~blk_phase_r;
      end else begin
        blk_cnt_r   <= blk_cnt_r + BLK_W'(1);
        blk_phase_r <= blk_phase_r;
      end
    end else begin
      blk_cnt_r   <= blk_cnt_r;
      blk_phase_r <= blk_phase_r;
    end
  end

  // Stage loads and transfer them to the display register only at a frame wrap.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      pend_val_r  <= {(4*N_DIGITS){1'b0}};
      pend_flag_r <= 1'b0;
      disp_val_r  <= {(4*N_DIGITS){1'b0}};
    end else begin
      if (i_LOAD) begin
        pend_val_r <= i_VALUE;
      end else begin
        pend_val_r <= pend_val_r;
      end
      if (wrap_s) begin
        // A load on the wrap cycle bypasses the pending stage entirely.
        if (i_LOAD) begin
          disp_val_r <= i_VALUE;
        end else if (pend_flag_r) begin
          disp_val_r <= pend_val_r;
        end else begin
          disp_val_r <= disp_val_r;
        end
        pend_flag_r <= 1'b0;
      end else begin
        disp_val_r  <= disp_val_r;
        pend_flag_r <= i_LOAD ? 1'b1 : pend_flag_r;
      end
    end
  end

  // Select the active digit's data and compute its logical (active-high) outputs.
  always_comb begin
    logic zero_run;
    onehot_s    = {N_DIGITS{1'b0}};
    lz_mask_s   = {N_DIGITS{1'b0}};
    cur_nib_s   = 4'h0;
    cur_dp_s    = 1'b0;
    cur_blink_s = 1'b0;
    zero_run    = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      onehot_s[k] = (idx_r == IDX_W'(k));
      cur_nib_s   = cur_nib_s | ({4{onehot_s[k]}} & disp_val_r[4*k +: 4]);
      cur_dp_s    = cur_dp_s | (onehot_s[k] & i_DP[k]);
      cur_blink_s = cur_blink_s | (onehot_s[k] & i_BLINK_EN[k]);
    end
    // A digit is a leading zero when it and every more significant nibble are zero.
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run & (disp_val_r[4*k +: 4] == 4'h0);
      lz_mask_s[k] = zero_run;
    end
    lz_mask_s[0] = 1'b0;
    cur_lz_s  = i_BLANK_LZ & (|(lz_mask_s & onehot_s));
    blinked_s = blk_phase_r & cur_blink_s;
    if (guard_s || blinked_s || cur_lz_s) begin
      seg_s = 7'b0000000;
    end else begin
      seg_s = seg_decode(cur_nib_s);
    end
    dp_s = cur_dp_s & ~guard_s & ~blinked_s;
    en_s = guard_s ? {N_DIGITS{1'b0}} : onehot_s;
  end

  // Output registers; polarity inversion is applied only here.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      seg_r        <= {7{POL}};
      dp_r         <= POL;
      en_r         <= {N_DIGITS{POL}};
      frame_done_r <= 1'b0;
    end else begin
      seg_r        <= seg_s ^ {7{POL}};
      dp_r         <= dp_s ^ POL;
      en_r         <= en_s ^ {N_DIGITS{POL}};
      frame_done_r <= wrap_s;
    end
  end

  assign o_SEVEN_SEG  = seg_r;
  assign o_DP         = dp_r;
  assign o_DIGIT_EN   = en_r;
  assign o_FRAME_DONE = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: two instances (active-high and active-low
// polarity) share all inputs; a frame-level reference model predicts every
// output cycle, and table vectors plus hand sequences cover the corner cases.
module tb_seven_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GC = 2;
  localparam int BF = 2;
  localparam int FR = ND * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp;
  logic [3:0]  blink_en;
  logic        blz;

  logic [6:0]  seg;
  logic        odp;
  logic [3:0]  en;
  logic        fd;
  logic [6:0]  seg_al;
  logic        dp_al;
  logic [3:0]  en_al;
  logic        fd_al;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .N_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(GC), .BLINK_FRAMES(BF), .ACTIVE_LOW(0)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .i_VALUE(value), .i_LOAD(load), .i_DP(dp),
    .i_BLINK_EN(blink_en), .i_BLANK_LZ(blz),
    .o_SEVEN_SEG(seg), .o_DP(odp), .o_DIGIT_EN(en), .o_FRAME_DONE(fd)
  );

  seven_seg_scan_driver #(
    .N_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(GC), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)
  ) dut_al (
    .i_CLK(clk), .i_RST(rst), .i_VALUE(value), .i_LOAD(load), .i_DP(dp),
    .i_BLINK_EN(blink_en), .i_BLANK_LZ(blz),
    .o_SEVEN_SEG(seg_al), .o_DP(dp_al), .o_DIGIT_EN(en_al), .o_FRAME_DONE(fd_al)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles since reset release, displayed and last loaded value.
  int          m_t;
  logic [15:0] m_disp;
  logic [15:0] m_last;
  logic [6:0]  seg_tab [16];

  logic [6:0]  cap_seg [4];
  logic [3:0]  cap_en  [4];
  logic        cap_dp  [4];

  typedef struct packed {
    logic [15:0] value;
    logic        blz;
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: predict outputs from the model position, clock, compare, advance model.
  task automatic step();
    logic [6:0] e_seg;
    logic [6:0] e_seg_al;
    logic       e_dp;
    logic [3:0] e_en;
    logic [3:0] e_en_al;
    logic       e_fd;
    logic [3:0] nib;
    int         slot;
    int         dig;
    int         frames;
    logic       guard;
    logic       blinked;
    logic       lzb;
    if (rst) begin
      e_seg = 7'h00; e_dp = 1'b0; e_en = 4'h0; e_fd = 1'b0;
    end else begin
      slot    = m_t % RD;
      dig     = (m_t / RD) % ND;
      frames  = m_t / FR;
      guard   = (slot < GC);
      blinked = (((frames / BF) % 2) == 1) && blink_en[dig];
      nib     = 4'((m_disp >> (4 * dig)) & 16'h000F);
      lzb     = blz && (dig > 0) && ((m_disp >> (4 * dig)) == 16'h0000);
      e_seg   = (guard || blinked || lzb) ? 7'h00 : seg_tab[nib];
      e_dp    = dp[dig] && !guard && !blinked;
      e_en    = guard ? 4'h0 : (4'b0001 << dig);
      e_fd    = (slot == RD - 1) && (dig == ND - 1);
    end
    e_seg_al = ~e_seg;
    e_en_al  = ~e_en;
    @(posedge clk);
    #1;
    chk("seg", {9'h0, seg}, {9'h0, e_seg});
    chk("dp", {15'h0, odp}, {15'h0, e_dp});
    chk("en", {12'h0, en}, {12'h0, e_en});
    chk("frame_done", {15'h0, fd}, {15'h0, e_fd});
    chk("seg_al", {9'h0, seg_al}, {9'h0, e_seg_al});
    chk("dp_al", {15'h0, dp_al}, {15'h0, ~e_dp});
    chk("en_al", {12'h0, en_al}, {12'h0, e_en_al});
    chk("frame_done_al", {15'h0, fd_al}, {15'h0, e_fd});
    if (rst) begin
      m_t = 0; m_disp = 16'h0000; m_last = 16'h0000;
    end else begin
      if (load) m_last = value;
      if ((m_t % FR) == FR - 1) m_disp = m_last;
      m_t++;
    end
  endtask

  task automatic align_frame();
    while ((m_t % FR) != 0) step();
  endtask

  // Steps one whole frame and records each digit's outputs mid-slot.
  task automatic capture_frame();
    int p;
    for (int i = 0; i < FR; i++) begin
      p = m_t;
      step();
      if ((p % RD) == 4) begin
        cap_seg[(p / RD) % ND] = seg;
        cap_en[(p / RD) % ND]  = en;
        cap_dp[(p / RD) % ND]  = odp;
      end
    end
  endtask

  initial begin
    int       n;
    int       en0_cnt;
    logic [3:0] exp_en;

    seg_tab[0]  = 7'b0111111; seg_tab[1]  = 7'b0000110; seg_tab[2]  = 7'b1011011;
    seg_tab[3]  = 7'b1001111; seg_tab[4]  = 7'b1100110; seg_tab[5]  = 7'b1101101;
    seg_tab[6]  = 7'b1111101; seg_tab[7]  = 7'b0000111; seg_tab[8]  = 7'b1111111;
    seg_tab[9]  = 7'b1100111; seg_tab[10] = 7'b1110111; seg_tab[11] = 7'b1111100;
    seg_tab[12] = 7'b0111001; seg_tab[13] = 7'b1011110; seg_tab[14] = 7'b1111001;
    seg_tab[15] = 7'b1110001;

    vecs[0] = '{16'h1234, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}};
    vecs[1] = '{16'h5678, 1'b0, {7'h6D, 7'h7D, 7'h07, 7'h7F}};
    vecs[2] = '{16'h9ABC, 1'b0, {7'h67, 7'h77, 7'h7C, 7'h39}};
    vecs[3] = '{16'hDEF0, 1'b0, {7'h5E, 7'h79, 7'h71, 7'h3F}};
    vecs[4] = '{16'h00A0, 1'b1, {7'h00, 7'h00, 7'h77, 7'h3F}};
    vecs[5] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[6] = '{16'h0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    vecs[7] = '{16'h0105, 1'b1, {7'h00, 7'h06, 7'h3F, 7'h6D}};

    m_t = 0; m_disp = 16'h0000; m_last = 16'h0000;
    rst = 1'b1; value = 16'h0000; load = 1'b0; dp = 4'h0; blink_en = 4'h0; blz = 1'b0;

    // Reset state, then the first cycle after release must still be off.
    repeat (3) step();
    chk("rst_seg", {9'h0, seg}, 16'h0000);
    chk("rst_en_al", {12'h0, en_al}, 16'h000F);
    rst = 1'b0;
    step();
    chk("post_rst_en", {12'h0, en}, 16'h0000);
    chk("post_rst_fd", {15'h0, fd}, 16'h0000);

    // Table vectors: decode and leading-zero blanking, one captured frame each.
    for (int i = 0; i < 8; i++) begin
      value = vecs[i].value;
      blz   = vecs[i].blz;
      load  = 1'b1;
      step();
      load  = 1'b0;
      align_frame();
      capture_frame();
      for (int d = 0; d < ND; d++) begin
        exp_en = 4'b0001 << d;
        chk($sformatf("vec%0d_seg_d%0d", i, d), {9'h0, cap_seg[d]}, {9'h0, vecs[i].segs[7*d +: 7]});
        chk($sformatf("vec%0d_en_d%0d", i, d), {12'h0, cap_en[d]}, {12'h0, exp_en});
      end
    end

    // Frame-done period and per-digit enable length.
    blz = 1'b0;
    n = 0;
    while (fd !== 1'b1 && n < 100) begin step(); n++; end
    chk("fd_seen", {15'h0, (n < 100)}, 16'h0001);
    n = 0; en0_cnt = 0;
    do begin
      step(); n++;
      if (en == 4'b0001) en0_cnt++;
    end while (fd !== 1'b1 && n < 100);
    chk("fd_period", 16'(n), 16'd32);
    chk("en0_cycles", 16'(en0_cnt), 16'd6);

    // Load on the wrap cycle shows from that wrap; two mid-frame loads: only the last shows next frame.
    while ((m_t % FR) != FR - 1) step();
    value = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    while ((m_t % FR) != 4) step();
    step();
    chk("wrap_load_d0", {9'h0, seg}, 16'h0066);
    while ((m_t % FR) != 10) step();
    value = 16'hBEEF; load = 1'b1; step(); load = 1'b0;
    while ((m_t % FR) != 16) step();
    value = 16'hCAFE; load = 1'b1; step(); load = 1'b0;
    while ((m_t % FR) != 28) step();
    step();
    chk("mid_frame_d3", {9'h0, seg}, 16'h0006);
    align_frame();
    capture_frame();
    chk("cafe_d0", {9'h0, cap_seg[0]}, 16'h0079);
    chk("cafe_d1", {9'h0, cap_seg[1]}, 16'h0071);
    chk("cafe_d2", {9'h0, cap_seg[2]}, 16'h0077);
    chk("cafe_d3", {9'h0, cap_seg[3]}, 16'h0039);

    // Blink on digit 0: lit 2 frames, off 2 frames, from a fresh reset.
    rst = 1'b1; step(); step(); rst = 1'b0;
    blink_en = 4'b0001; dp = 4'b0001;
    for (int f = 0; f < 5; f++) begin
      capture_frame();
      chk($sformatf("blink_seg_f%0d", f), {9'h0, cap_seg[0]}, ((f % 4) < 2) ? 16'h003F : 16'h0000);
      chk($sformatf("blink_dp_f%0d", f), {15'h0, cap_dp[0]}, ((f % 4) < 2) ? 16'h0001 : 16'h0000);
      chk($sformatf("blink_d1_f%0d", f), {9'h0, cap_seg[1]}, 16'h003F);
    end
    blink_en = 4'h0; dp = 4'h0;

    // Reset on slot 5 of digit 2; active-low outputs all 1, restart at digit 0.
    align_frame();
    while ((m_t % FR) != 21) step();
    rst = 1'b1;
    step();
    chk("al_rst_seg", {9'h0, seg_al}, 16'h007F);
    chk("al_rst_en", {12'h0, en_al}, 16'h000F);
    chk("al_rst_dp", {15'h0, dp_al}, 16'h0001);
    chk("al_rst_fd", {15'h0, fd_al}, 16'h0000);
    step();
    rst = 1'b0;
    step();
    chk("al_guard0_en", {12'h0, en_al}, 16'h000F);
    step();
    chk("al_guard1_en", {12'h0, en_al}, 16'h000F);
    step();
    chk("al_first_en", {12'h0, en_al}, 16'h000E);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 1500; c++) begin
      load  = ($urandom_range(0, 19) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        dp       = 4'($urandom);
        blink_en = 4'($urandom);
        blz      = 1'($urandom);
      end
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0; load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
